// File: rtl/best_match_sel.sv
// best_match_sel: pick best/second Hamming distance per query and apply threshold plus ratio tests
module best_match_sel #(
  parameter int IDX_W     = 10,
  parameter int MAX_DIST  = 64,
  parameter int RATIO_NUM = 4,
  parameter int RATIO_DEN = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [IDX_W-1:0] i_cand_num,
  input  logic             i_ready,
  input  logic [15:0]      i_value,
  output logic             o_busy,
  output logic             o_ready,
  output logic [IDX_W-1:0] o_match_idx,
  output logic [15:0]      o_best_dist,
  output logic [15:0]      o_second_dist,
  output logic             o_match_valid
);
  localparam int RMAX = RATIO_NUM > RATIO_DEN ? RATIO_NUM : RATIO_DEN;
  localparam int PW = 17 + $clog2(RMAX);
  typedef enum logic [1:0] {IDLE, ACCUM, EVAL, DONE} state_t;
  state_t state, state_d;
  logic [IDX_W-1:0] cnt, num, idx;
  logic [15:0] best, second;
  logic [PW-1:0] lhs, rhs;
  logic acc, last, valid;
  assign acc = state == ACCUM && i_ready;
  assign last = cnt == num - 1'b1;
  assign lhs = PW'(best) * PW'(RATIO_DEN);
  assign rhs = PW'(second) * PW'(RATIO_NUM);
  assign valid = best <= 16'(MAX_DIST) && lhs < rhs;
  assign o_busy = state != IDLE;
  always_comb begin
    state_d = IDLE;
    if (state == IDLE)
      state_d = i_start ? (i_cand_num != '0 ? ACCUM : EVAL) : IDLE;
    else if (state == ACCUM)
      state_d = acc && last ? EVAL : ACCUM;
    else if (state == EVAL)
      state_d = DONE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      cnt <= '0;
      num <= '0;
      idx <= '0;
      best <= 16'hFFFF;
      second <= 16'hFFFF;
      o_ready <= 1'b0;
      o_match_idx <= '0;
      o_best_dist <= 16'hFFFF;
      o_second_dist <= 16'hFFFF;
      o_match_valid <= 1'b0;
    end else begin
      state <= state_d;
      o_ready <= state == EVAL;
      if (state == IDLE && i_start) begin
        cnt <= '0;
        num <= i_cand_num;
        idx <= '0;
        best <= 16'hFFFF;
        second <= 16'hFFFF;
      end
      if (acc) begin
        cnt <= cnt + 1'b1;
        if (i_value < best) begin
          second <= best;
          best <= i_value;
          idx <= cnt;
        end else if (i_value < second) begin
          second <= i_value;
        end
      end
      if (state == EVAL) begin
        o_match_idx <= idx;
        o_best_dist <= best;
        o_second_dist <= second;
        o_match_valid <= valid;
      end
    end
  end
endmodule
